// File: rtl/riscv_wb_unit_pkg.sv
// Shared configuration for the write-back unit: datapath width, register file
// geometry, load funct3 encodings and the load-queue entry layout.
package riscv_wb_unit_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned NUM_REGS = 32;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // One formatted load result waiting for a regfile write slot.
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } lq_entry_t;

  localparam int unsigned LQ_W = $bits(lq_entry_t);

endpackage

// File: rtl/riscv_wb_fifo.sv
// Small synchronous FIFO holding formatted load results.
// Ports: i_clk/i_rstn clock and async active-low reset; i_push/i_wdata write
// side (ignored when full); i_pop read side (ignored when empty); o_rdata_c is
// the current head; o_full_c/o_empty_c are derived from registered pointers.
module riscv_wb_fifo #(
  parameter int unsigned WIDTH = 37,
  parameter int unsigned DEPTH = 2
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata_c,
  output logic             o_full_c,
  output logic             o_empty_c
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = i_push && !o_full_c;
  assign do_pop  = i_pop && !o_empty_c;

  // Pointer state.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage; contents are qualified by the pointers so no reset is needed.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata_c = mem[rd_ptr[AW-1:0]];
  assign o_empty_c = (wr_ptr == rd_ptr);
  assign o_full_c  = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/riscv_wb_unit.sv
// Write-side driver of the integer register file. Merges ALU results and
// formatted load responses into one registered write per cycle (ALU has
// priority, loads wait in a small queue) and tracks outstanding loads in a
// pending scoreboard so decode can stall on hazards.
// Ports: i_ex_* ALU result (always accepted); i_ld_*/o_ld_ready load response
// handshake; i_iss_* load issue from decode; i_dec_* decode operands checked by
// o_hazard; o_ld_fmt_err pulses on an illegal load funct3; o_rd_* regfile port.
module riscv_wb_unit
  import riscv_wb_unit_pkg::*;
#(
  parameter int unsigned LQ_DEPTH = 2
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_ex_valid,
  input  logic [REG_AW-1:0] i_ex_rd,
  input  logic [XLEN-1:0]   i_ex_data,
  input  logic              i_ld_valid,
  output logic              o_ld_ready,
  input  logic [REG_AW-1:0] i_ld_rd,
  input  logic [2:0]        i_ld_funct3,
  input  logic [1:0]        i_ld_addr_lo,
  input  logic [XLEN-1:0]   i_ld_rdata,
  input  logic              i_iss_ld_valid,
  input  logic [REG_AW-1:0] i_iss_rd,
  input  logic [REG_AW-1:0] i_dec_rs1,
  input  logic [REG_AW-1:0] i_dec_rs2,
  input  logic [REG_AW-1:0] i_dec_rd,
  output logic              o_hazard,
  output logic              o_ld_fmt_err,
  output logic              o_rd_wen,
  output logic [REG_AW-1:0] o_rd_addr,
  output logic [XLEN-1:0]   o_rd_data
);

  lq_entry_t             ld_entry;
  lq_entry_t             lq_head;
  logic                  lq_full;
  logic                  lq_empty;
  logic                  ld_push;
  logic                  lq_pop;
  logic [XLEN-1:0]       ld_data;
  logic                  ld_err_c;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [NUM_REGS-1:0]   pending;
  logic [NUM_REGS-1:0]   pending_nxt;

  // Ready depends only on queue state, never on i_ld_valid.
  assign o_ld_ready = !lq_full;
  assign ld_push    = i_ld_valid && !lq_full;
  // Queue drains only in cycles the ALU leaves the write port free.
  assign lq_pop     = !i_ex_valid && !lq_empty;

  // Load formatter: select and extend the addressed byte/half at enqueue.
  always_comb begin
    ld_data  = '0;
    ld_err_c = 1'b0;
    case (i_ld_addr_lo)
      2'd0:    ld_byte = i_ld_rdata[7:0];
      2'd1:    ld_byte = i_ld_rdata[15:8];
      2'd2:    ld_byte = i_ld_rdata[23:16];
      default: ld_byte = i_ld_rdata[31:24];
    endcase
    // Misaligned halves fall back to the half selected by addr_lo[1].
    ld_half = i_ld_addr_lo[1] ? i_ld_rdata[31:16] : i_ld_rdata[15:0];
    case (i_ld_funct3)
      F3_LB:   ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      F3_LW:   ld_data = i_ld_rdata;
      F3_LBU:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      F3_LHU:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_err_c = 1'b1;
    endcase
  end

  assign ld_entry = '{rd: i_ld_rd, data: ld_data};

  riscv_wb_fifo #(
    .WIDTH (LQ_W),
    .DEPTH (LQ_DEPTH)
  ) u_lq (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_push    (ld_push),
    .i_wdata   (ld_entry),
    .i_pop     (lq_pop),
    .o_rdata_c (lq_head),
    .o_full_c  (lq_full),
    .o_empty_c (lq_empty)
  );

  // Scoreboard next state: clear on pop, then set on issue so set wins.
  always_comb begin
    pending_nxt = pending;
    if (lq_pop)         pending_nxt[lq_head.rd] = 1'b0;
    if (i_iss_ld_valid) pending_nxt[i_iss_rd]   = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) pending <= '0;
    else         pending <= pending_nxt;
  end

  assign o_hazard = pending[i_dec_rs1] | pending[i_dec_rs2] | pending[i_dec_rd];

  // Registered regfile write port; x0 writes are suppressed but still consume a slot.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_rd_wen     <= 1'b0;
      o_rd_addr    <= '0;
      o_rd_data    <= '0;
      o_ld_fmt_err <= 1'b0;
    end else begin
      o_ld_fmt_err <= ld_push && ld_err_c;
      if (i_ex_valid) begin
        o_rd_wen  <= (i_ex_rd != '0);
        o_rd_addr <= i_ex_rd;
        o_rd_data <= i_ex_data;
      end else if (!lq_empty) begin
        o_rd_wen  <= (lq_head.rd != '0);
        o_rd_addr <= lq_head.rd;
        o_rd_data <= lq_head.data;
      end else begin
        o_rd_wen  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_riscv_wb_unit.sv
// Directed bench for riscv_wb_unit with a queue-based reference model checked
// every cycle, plus literal expectations for the documented scenarios.
module tb_riscv_wb_unit;

  localparam int unsigned LQD = 2;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_ex_valid, i_ld_valid, i_iss_ld_valid;
  logic [4:0]  i_ex_rd, i_ld_rd, i_iss_rd, i_dec_rs1, i_dec_rs2, i_dec_rd;
  logic [31:0] i_ex_data, i_ld_rdata;
  logic [2:0]  i_ld_funct3;
  logic [1:0]  i_ld_addr_lo;
  logic        o_ld_ready, o_hazard, o_ld_fmt_err, o_rd_wen;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;

  int nvec = 0;
  int nerr = 0;

  riscv_wb_unit #(.LQ_DEPTH(LQD)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn),
    .i_ex_valid(i_ex_valid), .i_ex_rd(i_ex_rd), .i_ex_data(i_ex_data),
    .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready), .i_ld_rd(i_ld_rd),
    .i_ld_funct3(i_ld_funct3), .i_ld_addr_lo(i_ld_addr_lo), .i_ld_rdata(i_ld_rdata),
    .i_iss_ld_valid(i_iss_ld_valid), .i_iss_rd(i_iss_rd),
    .i_dec_rs1(i_dec_rs1), .i_dec_rs2(i_dec_rs2), .i_dec_rd(i_dec_rd),
    .o_hazard(o_hazard), .o_ld_fmt_err(o_ld_fmt_err),
    .o_rd_wen(o_rd_wen), .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load formatting computed by shifting the word down to the lane.
  function automatic logic [32:0] fmt(input logic [2:0] f3, input logic [1:0] lo,
                                      input logic [31:0] w);
    logic [31:0] b, h;
    b = w >> (8 * lo);
    h = w >> (16 * lo[1]);
    case (f3)
      3'b000:  return {1'b0, 32'($signed(b[7:0]))};
      3'b001:  return {1'b0, 32'($signed(h[15:0]))};
      3'b010:  return {1'b0, w};
      3'b100:  return {1'b0, 32'(b[7:0])};
      3'b101:  return {1'b0, 32'(h[15:0])};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  // Reference model state.
  logic [4:0]  mq_rd[$];
  logic [31:0] mq_data[$];
  logic [31:0] m_pend = '0;
  logic        m_wen = 1'b0, m_err = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;

  initial forever begin
    @(posedge i_clk or negedge i_rstn);
    if (!i_rstn) begin
      mq_rd.delete(); mq_data.delete();
      m_pend = '0; m_wen = 1'b0; m_addr = '0; m_data = '0; m_err = 1'b0;
    end else begin
      logic        acc;
      logic [32:0] f;
      acc = i_ld_valid && (mq_rd.size() < LQD);
      f   = fmt(i_ld_funct3, i_ld_addr_lo, i_ld_rdata);
      if (i_ex_valid) begin
        m_wen = (i_ex_rd != 0); m_addr = i_ex_rd; m_data = i_ex_data;
      end else if (mq_rd.size() > 0) begin
        m_addr = mq_rd.pop_front(); m_data = mq_data.pop_front();
        m_wen = (m_addr != 0);
        m_pend[m_addr] = 1'b0;
      end else begin
        m_wen = 1'b0;
      end
      if (i_iss_ld_valid && i_iss_rd != 0) m_pend[i_iss_rd] = 1'b1;
      m_err = acc && f[32];
      if (acc) begin
        mq_rd.push_back(i_ld_rd);
        mq_data.push_back(f[31:0]);
      end
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge i_clk);
    chk("wen", 32'(o_rd_wen), 32'(m_wen));
    if (m_wen) begin
      chk("addr", 32'(o_rd_addr), 32'(m_addr));
      chk("data", o_rd_data, m_data);
    end
    chk("ready", 32'(o_ld_ready), 32'(mq_rd.size() < LQD));
    chk("hazard", 32'(o_hazard),
        32'(m_pend[i_dec_rs1] | m_pend[i_dec_rs2] | m_pend[i_dec_rd]));
    chk("fmt_err", 32'(o_ld_fmt_err), 32'(m_err));
  end

  task automatic tick();
    @(negedge i_clk);
    #1;
  endtask

  task automatic idle();
    i_ex_valid = 0; i_ex_rd = 0; i_ex_data = 0;
    i_ld_valid = 0; i_ld_rd = 0; i_ld_funct3 = 3'b010; i_ld_addr_lo = 0; i_ld_rdata = 0;
    i_iss_ld_valid = 0; i_iss_rd = 0;
    i_dec_rs1 = 0; i_dec_rs2 = 0; i_dec_rd = 0;
  endtask

  task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo,
                      input logic [31:0] w);
    i_ld_valid = 1; i_ld_rd = rd; i_ld_funct3 = f3; i_ld_addr_lo = lo; i_ld_rdata = w;
  endtask

  logic [2:0]  t_f3[5]  = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b011};
  logic [1:0]  t_lo[5]  = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
  logic [31:0] t_exp[5] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF, 32'h00007F01, 32'h0};
  logic [4:0]  seen[$];
  logic [4:0]  bp_exp[7] = '{5'd20, 5'd21, 5'd22, 5'd23, 5'd10, 5'd11, 5'd12};

  initial begin
    idle();
    tick(); tick();
    chk("rst_wen", 32'(o_rd_wen), 32'd0);
    chk("rst_addr", 32'(o_rd_addr), 32'd0);
    chk("rst_data", o_rd_data, 32'd0);
    chk("rst_ready", 32'(o_ld_ready), 32'd1);
    chk("rst_hazard", 32'(o_hazard), 32'd0);
    i_rstn = 1;
    tick();

    // ALU-only write.
    i_ex_valid = 1; i_ex_rd = 5; i_ex_data = 32'h1234;
    tick();
    idle();
    chk("alu_wen", 32'(o_rd_wen), 32'd1);
    chk("alu_addr", 32'(o_rd_addr), 32'd5);
    chk("alu_data", o_rd_data, 32'h1234);
    tick();
    chk("alu_wen_off", 32'(o_rd_wen), 32'd0);

    // Load formatting.
    for (int i = 0; i < 5; i++) begin
      load(5'(i + 1), t_f3[i], t_lo[i], 32'h80FF7F01);
      tick();
      idle();
      chk("fmt_err_pulse", 32'(o_ld_fmt_err), 32'(i == 4));
      chk("fmt_wen_early", 32'(o_rd_wen), 32'd0);
      tick();
      chk("fmt_wen", 32'(o_rd_wen), 32'd1);
      chk("fmt_addr", 32'(o_rd_addr), 32'(i + 1));
      chk("fmt_data", o_rd_data, t_exp[i]);
      chk("fmt_err_clear", 32'(o_ld_fmt_err), 32'd0);
    end
    tick();

    // ALU and load collide.
    i_ex_valid = 1; i_ex_rd = 3; i_ex_data = 32'hAAA;
    load(5'd4, 3'b010, 2'd0, 32'h4444);
    tick();
    idle();
    chk("col_first", 32'(o_rd_addr), 32'd3);
    chk("col_first_data", o_rd_data, 32'hAAA);
    tick();
    chk("col_second", 32'(o_rd_addr), 32'd4);
    chk("col_second_data", o_rd_data, 32'h4444);
    tick();

    // Backpressure: 4 ALU cycles with 3 loads offered.
    begin
      int li = 0;
      seen.delete();
      for (int c = 0; c < 16; c++) begin
        logic acc;
        i_ex_valid = (c < 4); i_ex_rd = 5'(20 + c); i_ex_data = 32'(c);
        if (li < 3) load(5'(10 + li), 3'b010, 2'd0, 32'(256 + li));
        else i_ld_valid = 0;
        acc = i_ld_valid && o_ld_ready;
        if (c == 2) chk("bp_ready_low", 32'(o_ld_ready), 32'd0);
        tick();
        if (acc) li++;
        if (o_rd_wen) seen.push_back(o_rd_addr);
      end
      idle();
      chk("bp_count", 32'(seen.size()), 32'd7);
      for (int k = 0; k < 7; k++)
        if (k < seen.size()) chk("bp_order", 32'(seen[k]), 32'(bp_exp[k]));
    end
    tick();

    // Scoreboard: issue, stall until popped.
    i_dec_rs2 = 7; i_iss_ld_valid = 1; i_iss_rd = 7;
    tick();
    i_iss_ld_valid = 0;
    chk("sb_set", 32'(o_hazard), 32'd1);
    tick(); tick();
    chk("sb_hold", 32'(o_hazard), 32'd1);
    load(5'd7, 3'b010, 2'd0, 32'h77);
    tick();
    i_ld_valid = 0;
    chk("sb_queued", 32'(o_hazard), 32'd1);
    tick();
    chk("sb_clear", 32'(o_hazard), 32'd0);
    chk("sb_wr", 32'(o_rd_addr), 32'd7);

    // Issue and pop of rd7 in the same cycle: stays pending.
    i_iss_ld_valid = 1; i_iss_rd = 7;
    tick();
    i_iss_ld_valid = 0;
    load(5'd7, 3'b010, 2'd0, 32'h78);
    tick();
    i_ld_valid = 0; i_iss_ld_valid = 1; i_iss_rd = 7;
    tick();
    i_iss_ld_valid = 0;
    chk("sb_set_wins", 32'(o_hazard), 32'd1);
    chk("sb_set_wins_wr", 32'(o_rd_data), 32'h78);
    load(5'd7, 3'b010, 2'd0, 32'h79);
    tick();
    i_ld_valid = 0;
    tick();
    chk("sb_final_clear", 32'(o_hazard), 32'd0);

    // rd0 load: no write, no hazard.
    idle();
    i_iss_ld_valid = 1; i_iss_rd = 0;
    tick();
    i_iss_ld_valid = 0;
    chk("x0_hazard", 32'(o_hazard), 32'd0);
    load(5'd0, 3'b010, 2'd0, 32'h5);
    tick();
    i_ld_valid = 0;
    tick();
    chk("x0_nowrite", 32'(o_rd_wen), 32'd0);
    tick();

    // Reset with queued loads and pending bits.
    i_ex_valid = 1; i_ex_rd = 15; i_ex_data = 32'hDEAD;
    i_iss_ld_valid = 1; i_iss_rd = 8; load(5'd8, 3'b010, 2'd0, 32'h8);
    tick();
    i_iss_rd = 9; load(5'd9, 3'b010, 2'd0, 32'h9);
    tick();
    i_iss_ld_valid = 0; i_ld_valid = 0; i_dec_rs1 = 8;
    tick();
    chk("pre_rst_hazard", 32'(o_hazard), 32'd1);
    chk("pre_rst_full", 32'(o_ld_ready), 32'd0);
    idle();
    i_dec_rs1 = 8;
    i_rstn = 0;
    #1;
    chk("mid_rst_wen", 32'(o_rd_wen), 32'd0);
    chk("mid_rst_addr", 32'(o_rd_addr), 32'd0);
    chk("mid_rst_data", o_rd_data, 32'd0);
    chk("mid_rst_err", 32'(o_ld_fmt_err), 32'd0);
    chk("mid_rst_ready", 32'(o_ld_ready), 32'd1);
    chk("mid_rst_hazard", 32'(o_hazard), 32'd0);
    tick();
    i_rstn = 1;
    tick(); tick();
    chk("post_rst_nowrite", 32'(o_rd_wen), 32'd0);
    chk("post_rst_hazard", 32'(o_hazard), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
